// File: rtl/wb_trace_buffer.sv
// Trace FIFO for core architectural write events (GRF writebacks and DM stores), PC-tagged.
// Accepts up to two events per edge, presents the head first-word-fall-through over valid/ready.
module wb_trace_buffer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DROP_R0 = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc,
    input  logic                     grf_we,
    input  logic [4:0]               grf_addr,
    input  logic [31:0]              grf_wd,
    input  logic                     dm_we,
    input  logic [31:0]              dm_addr,
    input  logic [31:0]              dm_wd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_kind,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic          kind_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic [AW-1:0] wptr_q, rptr_q, dm_slot;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q;
    logic [15:0]   drop_q, drop_d;
    logic [16:0]   drop_sum;
    logic [1:0]    n_drop;
    logic [AW+1:0] free;
    logic          grf_req, dm_req, grf_acc, dm_acc, pop;

    always_comb begin
        grf_req = grf_we && !((DROP_R0 != 0) && (grf_addr == 5'd0));
        dm_req  = dm_we;
        pop     = (level_q != '0) && out_ready;
        // A pop on this edge frees a slot for a push on the same edge.
        free    = (AW+2)'(DEPTH) - (AW+2)'(level_q) + (AW+2)'(pop);
        grf_acc = grf_req && (free != '0);
        dm_acc  = dm_req && (free > (AW+2)'(grf_acc));
        dm_slot = wptr_q + AW'(grf_acc);
        n_drop  = 2'(grf_req && !grf_acc) + 2'(dm_req && !dm_acc);
        level_d = level_q + (AW+1)'(grf_acc) + (AW+1)'(dm_acc) - (AW+1)'(pop);
        drop_sum = {1'b0, drop_q} + 17'(n_drop);
        drop_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (grf_acc) begin
            kind_mem[wptr_q] <= 1'b0;
            pc_mem[wptr_q]   <= pc;
            addr_mem[wptr_q] <= {27'd0, grf_addr};
            data_mem[wptr_q] <= grf_wd;
        end
        if (dm_acc) begin
            kind_mem[dm_slot] <= 1'b1;
            pc_mem[dm_slot]   <= pc;
            addr_mem[dm_slot] <= dm_addr;
            data_mem[dm_slot] <= dm_wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wptr_q  <= wptr_q + AW'(grf_acc) + AW'(dm_acc);
            rptr_q  <= rptr_q + AW'(pop);
            level_q <= level_d;
            drop_q  <= drop_d;
            if (n_drop != 2'd0) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = (level_q != '0);
        out_kind  = out_valid ? kind_mem[rptr_q] : 1'b0;
        out_pc    = out_valid ? pc_mem[rptr_q]   : 32'd0;
        out_addr  = out_valid ? addr_mem[rptr_q] : 32'd0;
        out_data  = out_valid ? data_mem[rptr_q] : 32'd0;
        level     = level_q;
        overflow  = overflow_q;
        drop_cnt  = drop_q;
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: a queue model tracks accepted events and drops,
// and every DUT handshake is checked against the queue head.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic        grf_we = 1'b0;
    logic [4:0]  grf_addr = '0;
    logic [31:0] grf_wd = '0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wd = '0;
    logic        out_ready = 1'b0;

    logic        out_valid, out_kind, overflow;
    logic [31:0] out_pc, out_addr, out_data;
    logic [4:0]  level;
    logic [15:0] drop_cnt;

    logic        o1_valid, o1_kind, o1_overflow;
    logic [31:0] o1_pc, o1_addr, o1_data;
    logic [4:0]  o1_level;
    logic [15:0] o1_drop_cnt;

    wb_trace_buffer #(.DEPTH(DEPTH), .DROP_R0(1)) dut (
        .clk(clk), .reset(reset), .pc(pc),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_wd(grf_wd),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    wb_trace_buffer #(.DEPTH(DEPTH), .DROP_R0(0)) dut_r0 (
        .clk(clk), .reset(reset), .pc(pc),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_wd(grf_wd),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .out_valid(o1_valid), .out_ready(out_ready), .out_kind(o1_kind),
        .out_pc(o1_pc), .out_addr(o1_addr), .out_data(o1_data),
        .level(o1_level), .overflow(o1_overflow), .drop_cnt(o1_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  m_drops = 0;
    bit  m_ovf = 1'b0;
    int  popped = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag);
        if (q.size() != 0) begin
            check({tag, ".valid"}, 32'(out_valid), 32'd1);
            check({tag, ".kind"},  32'(out_kind),  32'(q[0].kind));
            check({tag, ".pc"},    out_pc,         q[0].pc);
            check({tag, ".addr"},  out_addr,       q[0].addr);
            check({tag, ".data"},  out_data,       q[0].data);
        end else begin
            check({tag, ".valid"}, 32'(out_valid), 32'd0);
            check({tag, ".pc0"},   out_pc,         32'd0);
            check({tag, ".data0"}, out_data,       32'd0);
        end
    endtask

    task automatic model_push(input bit kind, input logic [31:0] p, input logic [31:0] a,
                              input logic [31:0] d);
        ev_t e;
        if (q.size() < DEPTH) begin
            e.kind = kind; e.pc = p; e.addr = a; e.data = d;
            q.push_back(e);
        end else begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
        end
    endtask

    // Called just after a falling edge; applies one cycle of stimulus and checks the result.
    task automatic cycle(input bit gwe, input logic [4:0] ga, input logic [31:0] gd,
                         input bit dwe, input logic [31:0] da, input logic [31:0] dd,
                         input logic [31:0] p, input bit rdy);
        grf_we = gwe; grf_addr = ga; grf_wd = gd;
        dm_we = dwe; dm_addr = da; dm_wd = dd;
        pc = p; out_ready = rdy;
        #1;
        check_head("head");
        if (rdy && q.size() != 0) begin
            void'(q.pop_front());
            popped++;
        end
        if (gwe && ga != 5'd0) model_push(1'b0, p, {27'd0, ga}, gd);
        if (dwe) model_push(1'b1, p, da, dd);
        @(posedge clk);
        @(negedge clk);
        grf_we = 1'b0; dm_we = 1'b0;
        check("level", 32'(level), 32'(q.size()));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rdy);
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.level", 32'(level), 32'd0);
        check("rst.kind", 32'(out_kind), 32'd0);
        check("rst.addr", out_addr, 32'd0);
        reset = 1'b0;
        idle(1'b0);

        // Single GRF event, held, then popped
        cycle(1'b1, 5'd8, 32'h1234, 1'b0, 32'd0, 32'd0, 32'h3000, 1'b0);
        check_head("t1.first");
        idle(1'b0);
        idle(1'b1);
        check("t1.level", 32'(level), 32'd0);

        // Register 0 write: dropped on DROP_R0=1, kept on DROP_R0=0
        cycle(1'b1, 5'd0, 32'h55, 1'b0, 32'd0, 32'd0, 32'h3008, 1'b0);
        check("t2.r0.level", 32'(o1_level), 32'd1);
        check("t2.r0.valid", 32'(o1_valid), 32'd1);
        check("t2.r0.addr", o1_addr, 32'd0);
        check("t2.r0.data", o1_data, 32'h55);
        idle(1'b1);
        check("t2.r0.drain", 32'(o1_level), 32'd0);

        // Dual event in one cycle
        cycle(1'b1, 5'd3, 32'd5, 1'b1, 32'h10, 32'd7, 32'h3004, 1'b0);
        check("t3.level", 32'(level), 32'd2);
        check("t3.kind0", 32'(out_kind), 32'd0);
        idle(1'b1);
        check("t3.kind1", 32'(out_kind), 32'd1);
        check("t3.addr1", out_addr, 32'h10);
        idle(1'b1);

        // Fill past capacity, then a dual event at full with a pop
        for (int i = 0; i < 17; i++)
            cycle(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b0, 32'd0, 32'd0, 32'h5000 + 32'(4 * i),
                  1'b0);
        check("t4.full", 32'(level), 32'd16);
        check("t4.drop1", 32'(drop_cnt), 32'd1);
        cycle(1'b1, 5'd9, 32'hBEEF, 1'b1, 32'h20, 32'hCAFE, 32'h6000, 1'b1);
        check("t4.level", 32'(level), 32'd16);
        check("t4.drop2", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 16; i++) idle(1'b1);

        // Async reset mid-cycle with an event presented during reset
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 5'd4, 32'(i), 1'b0, 32'd0, 32'd0, 32'h7000, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("t5.valid", 32'(out_valid), 32'd0);
        check("t5.level", 32'(level), 32'd0);
        check("t5.ovf", 32'(overflow), 32'd0);
        check("t5.drop", 32'(drop_cnt), 32'd0);
        grf_we = 1'b1; grf_addr = 5'd6; dm_we = 1'b1;
        @(posedge clk);
        @(negedge clk);
        grf_we = 1'b0; dm_we = 1'b0;
        reset = 1'b0;
        q.delete();
        m_drops = 0;
        m_ovf = 1'b0;
        idle(1'b0);

        // Alternating stream with 50% reader duty, wraps pointers and overflows
        base = popped;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0)
                cycle(1'b1, 5'(i % 31 + 1), 32'hA000 + 32'(i), 1'b0, 32'd0, 32'd0,
                      32'h8000 + 32'(4 * i), 1'(i % 2));
            else
                cycle(1'b0, 5'd0, 32'd0, 1'b1, 32'h100 + 32'(4 * i), 32'hD000 + 32'(i),
                      32'h8000 + 32'(4 * i), 1'(i % 2));
        end
        check("t6.sum", 32'(level) + 32'(drop_cnt) + 32'(popped - base), 32'd40);
        for (int i = 0; i < 20; i++) idle(1'b1);
        check("t6.empty", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
